apb_host_master: RTL and testbench



---
 rtl/apb_host_pkg.sv | 36 +++
 rtl/apb_host_master_if.sv | 39 +++
 rtl/apb_timeout_cnt.sv | 37 +++
 rtl/apb_host_master.sv | 117 +++++++++++
 tb/tb_apb_host_master.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/apb_host_pkg.sv
// Shared types and constants for the APB host master and the serial-line bridge register bank.
package apb_host_pkg;

  localparam int unsigned ADDR_WIDTH = 16;

  localparam logic [ADDR_WIDTH-1:0] DATA_REG_ADDR   = 16'h0000;
  localparam logic [ADDR_WIDTH-1:0] CONFIG_REG_ADDR = 16'h0004;
  localparam logic [ADDR_WIDTH-1:0] STATUS_REG_ADDR = 16'h0008;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            strb;
  } apb_cmd_t;

  // Reads carry no payload: wdata and strb are zeroed so they never reach the bus.
  function automatic apb_cmd_t make_cmd(input logic                  write,
                                        input logic [ADDR_WIDTH-1:0] addr,
                                        input logic [31:0]           wdata,
                                        input logic [3:0]            strb);
    apb_cmd_t cmd;
    cmd.write = write;
    cmd.addr  = addr;
    cmd.wdata = write ? wdata : 32'h0;
    cmd.strb  = write ? strb : 4'h0;
    return cmd;
  endfunction

endpackage

// File: rtl/apb_host_master_if.sv
// Command/response streams and APB bus of the host master; master modport is the initiator side.
interface apb_host_master_if #(
  parameter int unsigned ADDR_WIDTH = apb_host_pkg::ADDR_WIDTH
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [31:0]           cmd_wdata;
  logic [3:0]            cmd_strb;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [31:0]           pwdata;
  logic [3:0]            pstrb;
  logic [31:0]           prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output paddr, psel, penable, pwrite, pwdata, pstrb
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  paddr, psel, penable, pwrite, pwdata, pstrb
  );
endinterface

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait-state counter; only compiled when APB_TIMEOUT_EN is defined.
`ifdef APB_TIMEOUT_EN
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic stall_i,
  output logic expired_o
);
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_next;

  assign cnt_next = {1'b0, cnt_q} + 17'd1;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (stall_i && (cnt_q != '1)) begin
      cnt_d = cnt_next[15:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the stalled cycle that would bring the count up to the limit.
  assign expired_o = stall_i && (cnt_next >= 17'(TIMEOUT_CYCLES));
endmodule
`endif

// File: rtl/apb_host_master.sv
// APB3/APB4 initiator: one transfer in flight, valid/ready command in, valid/ready response out.
// Optional ACCESS timeout enabled by defining APB_TIMEOUT_EN.
module apb_host_master
  import apb_host_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = apb_host_pkg::ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic               pclk,
  input logic               preset,
  apb_host_master_if.master bus
);
  // The command register uses the package address width; ADDR_WIDTH must not exceed it.
  localparam int unsigned PkgAddrW = apb_host_pkg::ADDR_WIDTH;

  apb_state_t  state_q, state_d;
  apb_cmd_t    cmd_q, cmd_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        cmd_accept;
  logic        timeout_hit;

  assign bus.cmd_ready = !preset && (state_q == IDLE) && (!rsp_valid_q || bus.rsp_ready);
  assign cmd_accept    = bus.cmd_valid && bus.cmd_ready;

`ifdef APB_TIMEOUT_EN
  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i    (pclk),
    .rst_i    (preset),
    .clear_i  (state_q == SETUP),
    .stall_i  ((state_q == ACCESS) && !bus.pready),
    .expired_o(timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          cmd_d   = make_cmd(bus.cmd_write, PkgAddrW'(bus.cmd_addr), bus.cmd_wdata,
                             bus.cmd_strb);
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // A completing pready wins over a timeout landing on the same cycle.
        if (bus.pready) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = cmd_q.write ? 32'h0 : bus.prdata;
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
          state_d       = IDLE;
        end else if (timeout_hit) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = 32'h0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.psel        = (state_q != IDLE);
  assign bus.penable     = (state_q == ACCESS);
  assign bus.paddr       = ADDR_WIDTH'(cmd_q.addr);
  assign bus.pwrite      = bus.psel && cmd_q.write;
  assign bus.pwdata      = bus.psel ? cmd_q.wdata : 32'h0;
  assign bus.pstrb       = bus.psel ? cmd_q.strb : 4'h0;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_host_master.sv
// Self-checking bench for apb_host_master: directed cases plus random transfers against a
// word-addressed memory reference model.
module tb_apb_host_master;
  import apb_host_pkg::*;

  localparam int unsigned TimeoutCycles = 16;
`ifdef APB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic pclk   = 1'b0;
  logic preset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] slv_mem [16];
  logic [31:0] ref_mem [16];

  apb_host_master_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  apb_host_master #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .pclk  (pclk),
    .preset(preset),
    .bus   (bus)
  );

  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs one transfer from the current negedge; acts as the APB slave and checks the result.
  task automatic run_xfer(input logic wr, input int idx, input logic [31:0] wdata,
                          input logic [3:0] strb, input int waits, input logic err,
                          input int hold, input logic pend);
    logic [15:0] addr;
    logic [31:0] exp_wdata, exp_rdata;
    logic [3:0]  exp_strb;
    logic        exp_to, exp_err;
    int          exp_lat, n, acc, lat;
    addr      = 16'(idx * 4);
    exp_wdata = wr ? wdata : 32'h0;
    exp_strb  = wr ? strb : 4'h0;
    exp_to    = TimeoutEn && (waits >= int'(TimeoutCycles));
    exp_lat   = exp_to ? 2 + int'(TimeoutCycles) : 3 + waits;
    exp_err   = exp_to || err;
    exp_rdata = (wr || exp_to) ? 32'h0 : ref_mem[idx];
    if (wr && !err && !exp_to) begin
      for (int b = 0; b < 4; b++) if (strb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
    end

    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
    #1 check_eq("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    @(posedge pclk);
    n   = 0;
    acc = 0;
    lat = -1;
    while (lat < 0 && n < exp_lat + 8) begin
      @(negedge pclk);
      n++;
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      if (n == 1) begin
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        check_eq("rsp_cleared", 32'(bus.rsp_valid), 32'd0);
        check_eq("setup_phase", 32'({bus.psel, bus.penable}), 32'b10);
      end
      if (bus.rsp_valid) begin
        lat = n;
      end else if (bus.psel) begin
        check_eq("paddr", 32'(bus.paddr), 32'(addr));
        check_eq("pwrite", 32'(bus.pwrite), 32'(wr));
        check_eq("pwdata", bus.pwdata, exp_wdata);
        check_eq("pstrb", 32'(bus.pstrb), 32'(exp_strb));
        if (bus.penable) begin
          if (acc == waits) begin
            bus.pready  = 1'b1;
            bus.pslverr = err;
            if (bus.pwrite) begin
              if (!err) begin
                for (int b = 0; b < 4; b++) begin
                  if (bus.pstrb[b]) slv_mem[bus.paddr[5:2]][8*b +: 8] = bus.pwdata[8*b +: 8];
                end
              end
            end else begin
              bus.prdata = slv_mem[bus.paddr[5:2]];
            end
          end
          acc++;
        end
      end
    end
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    check_eq("rsp_latency", 32'(lat), 32'(exp_lat));
    check_eq("idle_psel_penable", 32'({bus.psel, bus.penable}), 32'd0);
    check_eq("idle_pwdata", bus.pwdata, 32'h0);
    check_eq("idle_paddr_hold", 32'(bus.paddr), 32'(addr));
    check_eq("rsp_rdata", bus.rsp_rdata, exp_rdata);
    check_eq("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    check_eq("rsp_timeout", 32'(bus.rsp_timeout), 32'(exp_to));

    if (pend) bus.cmd_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      #1 check_eq("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      @(negedge pclk);
      check_eq("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("hold_rsp_rdata", bus.rsp_rdata, exp_rdata);
      check_eq("hold_rsp_err", 32'(bus.rsp_err), 32'(exp_err));
      check_eq("hold_psel", 32'(bus.psel), 32'd0);
    end
    bus.rsp_ready = 1'b1;
  endtask

  initial begin
    logic        wr, err, pend;
    int          idx, waits, hold;
    logic [31:0] wdata;
    logic [3:0]  strb;

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = 32'h0;
    bus.cmd_strb  = 4'h0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = 32'h0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      slv_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end

    #1;
    check_eq("reset_psel_penable", 32'({bus.psel, bus.penable}), 32'd0);
    check_eq("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("reset_paddr", 32'(bus.paddr), 32'd0);
    check_eq("reset_pwdata_pstrb", bus.pwdata | 32'(bus.pstrb), 32'd0);
    check_eq("reset_rsp_flags", 32'({bus.rsp_err, bus.rsp_timeout}), 32'd0);
    @(negedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);

    // Zero-wait write, then a read with three wait states of the value stored beforehand.
    run_xfer(1'b1, 1, 32'hA5A5_5A5A, 4'hF, 0, 1'b0, 0, 1'b0);
    run_xfer(1'b1, 2, 32'h1234_5678, 4'hF, 0, 1'b0, 0, 1'b0);
    run_xfer(1'b0, 2, 32'hDEAD_BEEF, 4'hF, 3, 1'b0, 0, 1'b0);
    // Erroring read, response held 5 cycles with the next command pending.
    run_xfer(1'b0, 1, 32'h0, 4'h0, 1, 1'b1, 5, 1'b1);
    run_xfer(1'b1, 5, 32'hCAFE_F00D, 4'b0101, 0, 1'b0, 2, 1'b0);
    run_xfer(1'b0, 5, 32'h0, 4'h0, 0, 1'b0, 0, 1'b0);
    // Stalled slave: aborts with the timeout build, otherwise waits 1000 cycles.
    run_xfer(1'b0, 3, 32'h0, 4'h0, 1000, 1'b0, 0, 1'b0);

    // Reset in the middle of ACCESS drops the transfer without a response.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 16'h000C;
    bus.cmd_wdata = 32'h5555_AAAA;
    bus.cmd_strb  = 4'hF;
    #1 check_eq("cmd_ready_pre_reset", 32'(bus.cmd_ready), 32'd1);
    @(posedge pclk);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge pclk);
    check_eq("access_before_reset", 32'({bus.psel, bus.penable}), 32'b11);
    #2 preset = 1'b1;
    #1;
    check_eq("reset_drop_bus", 32'({bus.psel, bus.penable}), 32'd0);
    check_eq("reset_drop_rsp", 32'(bus.rsp_valid), 32'd0);
    @(negedge pclk);
    preset = 1'b0;
    repeat (3) begin
      @(negedge pclk);
      check_eq("post_reset_no_rsp", 32'({bus.rsp_valid, bus.psel}), 32'd0);
    end
    #1 check_eq("post_reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge pclk);
    run_xfer(1'b0, 3, 32'h0, 4'h0, 0, 1'b0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      wr    = 1'($urandom_range(0, 1));
      idx   = int'($urandom_range(0, 15));
      wdata = $urandom;
      strb  = 4'($urandom_range(0, 15));
      waits = int'($urandom_range(0, 3));
      err   = ($urandom_range(0, 4) == 0);
      hold  = int'($urandom_range(0, 2));
      pend  = (hold > 0) && ($urandom_range(0, 1) == 1);
      run_xfer(wr, idx, wdata, strb, waits, err, hold, pend);
    end

    @(negedge pclk);
    bus.rsp_ready = 1'b0;
    check_eq("final_rsp_consumed", 32'(bus.rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
